rom_arbiter: RTL and testbench

- Clocked arbiter sharing the single instruction/constant ROM between two requesters: instruction fetch (port F) and load unit (port L).
- Requesters use two-phase (toggle) req/ack handshakes.
- ROM side drives the ROM's toggle trigger and samples its ready level and data word.
- Sits between the fetch/load stages and the ROM in the core's memory subsystem.

---
 rtl/rom_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rom_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one instruction/constant ROM between instruction fetch
// (port F) and the load unit (port L). Both requesters use two-phase toggle
// req/ack handshakes; the ROM side uses a toggle trigger plus a ready level.
// Optional feature: define ROM_ARB_CACHE_EN to add a one-entry last-read cache.
module rom_arbiter #(
  parameter int WAIT_CYCLES = 2,  // clocks after a trigger toggle before sampling romReady (>= 1)
  parameter int SYNC_STAGES = 2   // synchronizer flops per incoming req line (>= 1)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetchReq,
  input  logic [31:0] fetchAddr,
  output logic        fetchAck,
  output logic [31:0] fetchData,
  input  logic        ldReq,
  input  logic [31:0] ldAddr,
  output logic        ldAck,
  output logic [31:0] ldData,
  output logic [31:0] romAddr,
  output logic        romTrigger,
  input  logic [31:0] romData,
  input  logic        romReady,
  output logic        busy
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;
  typedef enum logic {PORT_F, PORT_L} port_t;

  state_t                 state, next_state;
  port_t                  winner, last_grant, grant_port;
  logic [SYNC_STAGES-1:0] sync_fetch, sync_ld;
  logic                   pend_f, pend_l, any_pend;
  logic [31:0]            grant_addr;
  logic [CW-1:0]          cnt;
  logic                   issue_rom;
  logic                   deliver;
  logic [31:0]            deliver_data;

`ifdef ROM_ARB_CACHE_EN
  logic        cache_valid;
  logic [31:0] cache_tag;
  logic [31:0] cache_data;
  logic        hit_q;
`endif

  // A port is pending while its synchronized request differs from its ack.
  assign pend_f   = sync_fetch[SYNC_STAGES-1] != fetchAck;
  assign pend_l   = sync_ld[SYNC_STAGES-1] != ldAck;
  assign any_pend = pend_f | pend_l;
  assign busy     = (state != IDLE);

  // Round-robin choice: F wins unless both pend and F was granted last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_port = PORT_L;
    if (pend_f && !(pend_l && last_grant == PORT_F)) grant_port = PORT_F;
    grant_addr = (grant_port == PORT_F) ? fetchAddr : ldAddr;
  end

  // Next-state logic for the access sequencer.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:  if (any_pend) next_state = ISSUE;
`ifdef ROM_ARB_CACHE_EN
      ISSUE: next_state = hit_q ? IDLE : WAIT;
`else
      ISSUE: next_state = WAIT;
`endif
      WAIT:  if (cnt == '0) next_state = CHECK;
      CHECK: if (romReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Decide when a result is handed back and where the word comes from.
  always_comb begin
`ifdef ROM_ARB_CACHE_EN
    issue_rom    = (state == ISSUE) && !hit_q;
    deliver      = ((state == CHECK) && romReady) || ((state == ISSUE) && hit_q);
    deliver_data = (state == ISSUE) ? cache_data : romData;
`else
    issue_rom    = (state == ISSUE);
    deliver      = (state == CHECK) && romReady;
    deliver_data = romData;
`endif
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all clocked state uses non-blocking assignments to avoid ordering races.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Request-line synchronizers; the last flop feeds the pending compare.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_fetch <= '0;
      sync_ld    <= '0;
    end else begin
      sync_fetch[0] <= fetchReq;
      sync_ld[0]    <= ldReq;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_fetch[i] <= sync_fetch[i-1];
        sync_ld[i]    <= sync_ld[i-1];
      end
    end
  end

  // Grant latch, ROM trigger, wait counter and result/ack delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      romAddr    <= '0;
      romTrigger <= 1'b0;
      winner     <= PORT_F;
      last_grant <= PORT_L;
      cnt        <= '0;
      fetchAck   <= 1'b0;
      fetchData  <= '0;
      ldAck      <= 1'b0;
      ldData     <= '0;
    end else begin
      if (state == IDLE && any_pend) begin
        romAddr    <= grant_addr;
        winner     <= grant_port;
        last_grant <= grant_port;
      end
      if (issue_rom) begin
        romTrigger <= ~romTrigger;
        cnt        <= CNT_LOAD;
      end
      if (state == WAIT && cnt != '0) cnt <= cnt - CW'(1);
      if (deliver) begin
        if (winner == PORT_F) begin
          fetchData <= deliver_data;
          fetchAck  <= ~fetchAck;
        end else begin
          ldData <= deliver_data;
          ldAck  <= ~ldAck;
        end
      end
    end
  end

`ifdef ROM_ARB_CACHE_EN
  // Last-read cache: hit decided at grant, filled by every ROM capture.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the single cache entry is cleared by reset; the ROM contents never change, so nothing else invalidates it.
    if (rst) begin
      cache_valid <= 1'b0;
      cache_tag   <= '0;
      cache_data  <= '0;
      hit_q       <= 1'b0;
    end else begin
      if (state == IDLE && any_pend) hit_q <= cache_valid && (grant_addr == cache_tag);
      if (state == CHECK && romReady) begin
        cache_valid <= 1'b1;
        cache_tag   <= romAddr;
        cache_data  <= romData;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed and randomized checks of rom_arbiter against a
// transaction-level model (expected word, latency, trigger count, RR order).
module tb_rom_arbiter;

  localparam int WAIT_CYCLES = 2;
  localparam int SYNC_STAGES = 2;
  localparam int MISS_LAT    = SYNC_STAGES + WAIT_CYCLES + 3; // edges from req drive to ack
  localparam int HIT_LAT     = SYNC_STAGES + 2;
  localparam int BOUND       = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fetchReq = 1'b0, ldReq = 1'b0;
  logic [31:0] fetchAddr = '0, ldAddr = '0;
  logic        fetchAck, ldAck, romTrigger, busy;
  logic [31:0] fetchData, ldData, romAddr;
  logic [31:0] romData = '0;
  logic        romReady = 1'b1;

  int tests = 0;
  int fails = 0;
  int trig_cnt = 0;
  int rom_lat = 1;

  // Model state: cache contents and which port was served last.
  bit          m_valid = 1'b0;
  logic [31:0] m_tag = '0;
  bit          m_last_l = 1'b1;

  rom_arbiter #(.WAIT_CYCLES(WAIT_CYCLES), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst),
    .fetchReq(fetchReq), .fetchAddr(fetchAddr), .fetchAck(fetchAck), .fetchData(fetchData),
    .ldReq(ldReq), .ldAddr(ldAddr), .ldAck(ldAck), .ldData(ldData),
    .romAddr(romAddr), .romTrigger(romTrigger), .romData(romData), .romReady(romReady),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A00001;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  // ROM: drops ready on each trigger toggle, returns the word rom_lat edges later.
  initial begin
    forever begin
      @(romTrigger);
      romReady = 1'b0;
      romData  = 32'hDEADBEEF;
      repeat (rom_lat) @(posedge clk);
      #1;
      romData  = rom_word(romAddr);
      romReady = 1'b1;
    end
  end

  // Count functional trigger toggles (reset-driven changes excluded).
  initial begin
    forever begin
      @(romTrigger);
      if (rst !== 1'b1) trig_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
`ifdef ROM_ARB_CACHE_EN
    return m_valid && (m_tag == a);
`else
    return 1'b0 && (a == m_tag);
`endif
  endfunction

  // Model bookkeeping after one access is served.
  task automatic model_serve(input bit is_l, input logic [31:0] a, input bit hit);
    if (!hit) begin
      m_valid = 1'b1;
      m_tag   = a;
    end
    m_last_l = is_l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    fetchReq = 1'b0;
    ldReq    = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    m_valid  = 1'b0;
    m_last_l = 1'b1;
    tick();
  endtask

  // One request on one port; checks latency, data, other ack, trigger count.
  task automatic single(input bit is_l, input logic [31:0] a, input string tag);
    bit   hit = model_hit(a);
    int   t0 = trig_cnt;
    int   n = 0;
    int   stall = (rom_lat > WAIT_CYCLES) ? rom_lat - WAIT_CYCLES : 0;
    int   exp_lat = hit ? HIT_LAT : MISS_LAT + stall;
    logic ack0 = is_l ? ldAck : fetchAck;
    logic oth0 = is_l ? fetchAck : ldAck;
    if (is_l) begin ldAddr = a; ldReq = ~ldReq; end
    else begin fetchAddr = a; fetchReq = ~fetchReq; end
    do begin
      tick();
      n++;
    end while (((is_l ? ldAck : fetchAck) == ack0) && n <= BOUND);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_data"}, is_l ? ldData : fetchData, rom_word(a));
    check({tag, "_other_ack"}, {31'b0, is_l ? fetchAck : ldAck}, {31'b0, oth0});
    check({tag, "_triggers"}, trig_cnt - t0, hit ? 0 : 1);
    check({tag, "_romaddr"}, romAddr, a);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    model_serve(is_l, a, hit);
  endtask

  // Both ports request on the same edge; round-robin decides the order.
  task automatic pair(input logic [31:0] af, input logic [31:0] al, input string tag);
    bit   first_l = ~m_last_l;
    bit   got_l;
    int   t0 = trig_cnt;
    int   exp_trig = 0;
    int   n = 0;
    logic pf = fetchAck, pl = ldAck;
    logic [31:0] a1 = first_l ? al : af;
    logic [31:0] a2 = first_l ? af : al;
    bit   h1, h2;
    h1 = model_hit(a1);
    model_serve(first_l, a1, h1);
    h2 = model_hit(a2);
    model_serve(~first_l, a2, h2);
    exp_trig = (h1 ? 0 : 1) + (h2 ? 0 : 1);
    fetchAddr = af; ldAddr = al;
    fetchReq = ~fetchReq; ldReq = ~ldReq;
    while (fetchAck == pf && ldAck == pl && n <= BOUND) begin tick(); n++; end
    got_l = (ldAck != pl);
    check({tag, "_order"}, {31'b0, got_l}, {31'b0, first_l});
    check({tag, "_first_data"}, first_l ? ldData : fetchData, rom_word(a1));
    n = 0;
    while (((first_l ? fetchAck : ldAck) == (first_l ? pf : pl)) && n <= BOUND) begin tick(); n++; end
    check({tag, "_second_ack"}, {31'b0, first_l ? fetchAck : ldAck}, {31'b0, ~(first_l ? pf : pl)});
    check({tag, "_second_data"}, first_l ? fetchData : ldData, rom_word(a2));
    check({tag, "_triggers"}, trig_cnt - t0, exp_trig);
  endtask

  initial begin
    int t0;
    int misses;
    // Reset values.
    tick();
    check("rst_fetchAck", {31'b0, fetchAck}, 32'd0);
    check("rst_ldAck", {31'b0, ldAck}, 32'd0);
    check("rst_romTrigger", {31'b0, romTrigger}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_fetchData", fetchData, 32'd0);
    check("rst_ldData", ldData, 32'd0);
    check("rst_romAddr", romAddr, 32'd0);
    rst = 1'b0;
    tick();

    // Basic fetch of word 0x10.
    rom_lat = 1;
    single(1'b0, 32'h10, "f10");
    check("f10_const", fetchData, 32'hE3A00001);

    // Simultaneous requests after reset: F first both times.
    do_reset();
    pair(32'h20, 32'h40, "pair1");
    check("pair1_last_l", {31'b0, m_last_l}, 32'd1);
    pair(32'h21, 32'h41, "pair2");

    // ROM holds ready low 5 extra cycles in CHECK.
    rom_lat = WAIT_CYCLES + 5;
    single(1'b1, 32'h33, "stall");
    rom_lat = 1;

    // Reset while in WAIT abandons the access.
    fetchAddr = 32'h55;
    fetchReq  = ~fetchReq;
    repeat (SYNC_STAGES + 2) tick();
    check("wait_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_trigger", {31'b0, romTrigger}, 32'd0);
    check("mid_rst_fetchAck", {31'b0, fetchAck}, 32'd0);
    check("mid_rst_romAddr", romAddr, 32'd0);
    check("mid_rst_fetchData", fetchData, 32'd0);
    fetchReq = 1'b0;
    ldReq    = 1'b0;
    repeat (WAIT_CYCLES + 4) tick();
    rst = 1'b0;
    m_valid  = 1'b0;
    m_last_l = 1'b1;
    t0 = trig_cnt;
    repeat (10) tick();
    check("post_rst_no_ack", {31'b0, fetchAck}, 32'd0);
    check("post_rst_no_trig", trig_cnt - t0, 0);
    single(1'b0, 32'h55, "post_rst");

    // Repeated read of 0x10 then L reads 0x11.
    t0 = trig_cnt;
    single(1'b0, 32'h10, "rep1");
    single(1'b0, 32'h10, "rep2");
    single(1'b1, 32'h11, "rep3");
`ifdef ROM_ARB_CACHE_EN
    check("rep_total_triggers", trig_cnt - t0, 2);
`else
    check("rep_total_triggers", trig_cnt - t0, 3);
`endif

    // Randomized traffic over a small address window.
    misses = 0;
    for (int i = 0; i < 40; i++) begin
      rom_lat = $urandom_range(1, WAIT_CYCLES + 3);
      if ($urandom_range(0, 2) == 0)
        pair(32'h100 + $urandom_range(0, 3), 32'h100 + $urandom_range(0, 3), "rnd_pair");
      else
        single(1'($urandom_range(0, 1)), 32'h100 + $urandom_range(0, 3), "rnd_single");
      misses++;
    end
    rom_lat = 1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
